// File: rtl/lcd12864_ctrl.sv
// LCD12864 (ST7920-class) write-only parallel bus controller.
// Initialises the panel, then mirrors a 4x16-byte shadow text buffer onto the screen,
// streaming only rows marked dirty. Two requesters share the buffer via round-robin.
`timescale 1ns/1ps
module lcd12864_ctrl #(
    parameter int unsigned DIV      = 8000,
    parameter int unsigned CLR_WAIT = 80000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [5:0] addr0,
    input  logic [7:0] data0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [5:0] addr1,
    input  logic [7:0] data1,
    output logic       gnt1,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);
    localparam int unsigned CntW  = $clog2(2 * DIV + 1);
    localparam int unsigned WaitW = $clog2(CLR_WAIT + 1);
    localparam logic [CntW-1:0]  LastCnt  = CntW'(2 * DIV);
    localparam logic [CntW-1:0]  EnOn     = CntW'(DIV);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(CLR_WAIT - 1);

    typedef enum logic [2:0] {StInit, StWaitClr, StIdle, StRowAddr, StRowData} state_e;

    state_e            state_q, state_d;
    logic [1:0]        init_idx_q, init_idx_d;
    logic [3:0]        col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic              done_q, done_d;
    logic [3:0]        dirty_q, dirty_d;
    logic              last_q;          // 1: port 1 was granted most recently
    logic [7:0]        shadow_q [64];
    logic              act_q, act_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              en_q, en_d;
    logic              rs_q;
    logic [7:0]        data_q;

    logic              wr_en;
    logic [5:0]        wr_addr;
    logic [7:0]        wr_data;
    logic              slot_free;
    logic              start, start_rs;
    logic [7:0]        start_byte;
    logic              sel_found;
    logic [1:0]        sel_row, cand;
    logic [7:0]        init_cmd, row_cmd;

    // Round-robin arbiter: on conflict the port not served last wins
    always_comb begin
        gnt0    = req0 & (~req1 | last_q);
        gnt1    = req1 & (~req0 | ~last_q);
        wr_en   = gnt0 | gnt1;
        wr_addr = gnt0 ? addr0 : addr1;
        wr_data = gnt0 ? data0 : data1;
    end

    // Pick the next dirty row, searching from the last-served row + 1
    always_comb begin
        sel_found = 1'b0;
        sel_row   = row_q;
        cand      = row_q;
        for (int i = 1; i <= 4; i++) begin
            cand = row_q + 2'(i);
            if (!sel_found && dirty_q[cand]) begin
                sel_found = 1'b1;
                sel_row   = cand;
            end
        end
    end

    // Command byte tables for init and row-address
    always_comb begin
        case (init_idx_q)
            2'd0, 2'd1: init_cmd = 8'h30;
            2'd2:       init_cmd = 8'h0C;
            default:    init_cmd = 8'h01;
        endcase
        case (row_q)
            2'd0:    row_cmd = 8'h80;
            2'd1:    row_cmd = 8'h90;
            2'd2:    row_cmd = 8'h88;
            default: row_cmd = 8'h98;
        endcase
    end

    // Sequencer next state; a new slot may start on the last cycle of the previous one
    always_comb begin
        slot_free  = ~act_q | (cnt_q == LastCnt);
        state_d    = state_q;
        init_idx_d = init_idx_q;
        col_d      = col_q;
        row_d      = row_q;
        wait_d     = wait_q;
        done_d     = done_q;
        dirty_d    = dirty_q;
        start      = 1'b0;
        start_rs   = 1'b0;
        start_byte = 8'h00;
        unique case (state_q)
            StInit: begin
                if (slot_free) begin
                    start      = 1'b1;
                    start_byte = init_cmd;
                    if (init_idx_q == 2'd3) begin
                        state_d = StWaitClr;
                        wait_d  = '0;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                    end
                end
            end
            StWaitClr: begin
                // Count only once the clear command's slot has fully finished
                if (!act_q) begin
                    if (wait_q == WaitLast) begin
                        start      = 1'b1;
                        start_byte = 8'h06;
                        state_d    = StIdle;
                        done_d     = 1'b1;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            StIdle: begin
                if (sel_found) begin
                    dirty_d[sel_row] = 1'b0;
                    row_d            = sel_row;
                    state_d          = StRowAddr;
                end
            end
            StRowAddr: begin
                if (slot_free) begin
                    start      = 1'b1;
                    start_byte = row_cmd;
                    col_d      = 4'd0;
                    state_d    = StRowData;
                end
            end
            StRowData: begin
                if (slot_free) begin
                    start      = 1'b1;
                    start_rs   = 1'b1;
                    start_byte = shadow_q[{row_q, col_q}];
                    if (col_q == 4'd15) begin
                        state_d = StIdle;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end
            default: state_d = StInit;
        endcase
        // A write after the scheduler's clear wins so the row is re-sent
        if (wr_en) begin
            dirty_d[wr_addr[5:4]] = 1'b1;
        end
    end

    // Byte-slot timer: en low for DIV cycles, high for DIV, then one low hold cycle
    always_comb begin
        act_d = act_q;
        cnt_d = cnt_q;
        if (start) begin
            act_d = 1'b1;
            cnt_d = '0;
        end else if (act_q) begin
            if (cnt_q == LastCnt) begin
                act_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        en_d = act_d & (cnt_d >= EnOn) & (cnt_d < LastCnt);
    end

    // State, slot and bus registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StInit;
            init_idx_q <= 2'd0;
            col_q      <= 4'd0;
            row_q      <= 2'd3;
            wait_q     <= '0;
            done_q     <= 1'b0;
            dirty_q    <= 4'hF;
            last_q     <= 1'b1;
            act_q      <= 1'b0;
            cnt_q      <= '0;
            en_q       <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            col_q      <= col_d;
            row_q      <= row_d;
            wait_q     <= wait_d;
            done_q     <= done_d;
            dirty_q    <= dirty_d;
            act_q      <= act_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            if (wr_en) begin
                last_q <= gnt1;
            end
            if (start) begin
                rs_q   <= start_rs;
                data_q <= start_byte;
            end
        end
    end

    // Shadow text buffer, cleared to spaces
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                shadow_q[i] <= 8'h20;
            end
        end else if (wr_en) begin
            shadow_q[wr_addr] <= wr_data;
        end
    end

    assign init_done = done_q;
    assign busy      = act_q | (state_q == StWaitClr);
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = en_q;
    assign lcd_data  = data_q;

endmodule

// File: tb/tb_lcd12864_ctrl.sv
// Directed bench for lcd12864_ctrl with DIV=2, CLR_WAIT=10.
`timescale 1ns/1ps
module tb_lcd12864_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [5:0] addr0, addr1;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, init_done, busy;
    logic       lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int rel;

    logic [8:0] bq [$];     // {rs, data} latched at each en falling edge
    int         tq [$];     // cycle of each falling edge
    int         hq [$];     // en-high length of each byte
    logic       iq [$];     // init_done seen at each falling edge
    logic [8:0] exp_q [$];
    logic [7:0] mem [64];
    logic [7:0] row_cmd_t [4] = '{8'h80, 8'h90, 8'h88, 8'h98};

    lcd12864_ctrl #(.DIV(2), .CLR_WAIT(10)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
        .init_done(init_done), .busy(busy),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor
    initial begin
        logic en_prev;
        int   hi_len;
        en_prev = 1'b0;
        hi_len  = 0;
        forever begin
            @(negedge clk);
            if (lcd_en) begin
                hi_len++;
            end else begin
                if (en_prev) begin
                    bq.push_back({lcd_rs, lcd_data});
                    tq.push_back(cyc);
                    hq.push_back(hi_len);
                    iq.push_back(init_done);
                end
                hi_len = 0;
            end
            en_prev = lcd_en;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_bus();
        bq.delete(); tq.delete(); hq.delete(); iq.delete(); exp_q.delete();
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (bq.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (bq.size() < n) check("timeout", bq.size(), n);
    endtask

    task automatic add_row(input int r);
        exp_q.push_back({1'b0, row_cmd_t[r]});
        for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, mem[r * 16 + c]});
    endtask

    task automatic cmp_bus(input string tag, input int base);
        check({tag, "_count"}, bq.size(), base + exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < bq.size()) check($sformatf("%s[%0d]", tag, i), bq[base + i], exp_q[i]);
        end
    endtask

    task automatic init_seq(input int r0, input string tag);
        exp_q.delete();
        exp_q.push_back(9'h030); exp_q.push_back(9'h030); exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001); exp_q.push_back(9'h006);
        wait_bytes(5, 200);
        cmp_bus(tag, 0);
        if (bq.size() >= 5) begin
            check({tag, "_t0"}, tq[0] - r0, 5);
            check({tag, "_t1"}, tq[1] - tq[0], 5);
            check({tag, "_t2"}, tq[2] - tq[1], 5);
            check({tag, "_t3"}, tq[3] - tq[2], 5);
            check({tag, "_clrgap"}, tq[4] - tq[3], 15);
            for (int i = 0; i < 5; i++) check($sformatf("%s_enhi%0d", tag, i), hq[i], 2);
            check({tag, "_done_pre"}, iq[3], 0);
            check({tag, "_done_06"}, iq[4], 1);
        end
        @(negedge clk);
        check({tag, "_init_done"}, init_done, 1);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; addr0 = 6'h00; data0 = 8'h00;
        req1 = 1'b0; addr1 = 6'h00; data1 = 8'h00;
        for (int i = 0; i < 64; i++) mem[i] = 8'h20;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_en", lcd_en, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_rw", lcd_rw, 0);
        check("rst_data", lcd_data, 8'h00);
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_done", init_done, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        rel = cyc;
        clear_bus();
        init_seq(rel, "init");

        // Full-screen paint after init
        @(negedge clk);
        check("busy_paint", busy, 1);
        exp_q.delete();
        for (int r = 0; r < 4; r++) add_row(r);
        wait_bytes(73, 800);
        repeat (40) @(posedge clk);
        cmp_bus("paint", 5);
        if (tq.size() >= 23) check("row_period", tq[22] - tq[5], 85);
        @(negedge clk);
        check("busy_idle", busy, 0);

        // Conflict: grants alternate 0,1,0 then port 1 alone
        clear_bus();
        @(negedge clk);
        req0 = 1'b1; addr0 = 6'h05; data0 = 8'h31;
        req1 = 1'b1; addr1 = 6'h30; data1 = 8'h32;
        #1 check("cf_g0_a", gnt0, 1); check("cf_g1_a", gnt1, 0);
        mem[6'h05] = 8'h31;
        @(negedge clk);
        addr0 = 6'h06; data0 = 8'h33;
        #1 check("cf_g0_b", gnt0, 0); check("cf_g1_b", gnt1, 1);
        mem[6'h30] = 8'h32;
        @(negedge clk);
        addr1 = 6'h31; data1 = 8'h34;
        #1 check("cf_g0_c", gnt0, 1); check("cf_g1_c", gnt1, 0);
        mem[6'h06] = 8'h33;
        @(negedge clk);
        req0 = 1'b0;
        #1 check("cf_g0_d", gnt0, 0); check("cf_g1_d", gnt1, 1);
        mem[6'h31] = 8'h34;
        @(negedge clk);
        req1 = 1'b0;
        // Row 0 is re-dirtied while its address command is going out
        add_row(0); add_row(3); add_row(0);
        wait_bytes(51, 600);
        repeat (40) @(posedge clk);
        cmp_bus("conflict", 0);

        // Single write while idle
        clear_bus();
        @(negedge clk);
        req0 = 1'b1; addr0 = 6'h13; data0 = 8'h41;
        #1 check("sw_gnt0", gnt0, 1); check("sw_gnt1", gnt1, 0);
        mem[6'h13] = 8'h41;
        @(negedge clk);
        req0 = 1'b0;
        #1 check("sw_gnt0_off", gnt0, 0);
        add_row(1);
        wait_bytes(17, 300);
        repeat (40) @(posedge clk);
        cmp_bus("single", 0);

        // Write into row 2 while it is streaming
        clear_bus();
        @(negedge clk);
        req1 = 1'b1; addr1 = 6'h20; data1 = 8'h20;
        #1 check("st_gnt1_a", gnt1, 1);
        @(negedge clk);
        req1 = 1'b0;
        wait_bytes(4, 200);
        @(negedge clk);
        req1 = 1'b1; addr1 = 6'h2A; data1 = 8'h58;
        #1 check("st_gnt1_b", gnt1, 1);
        mem[6'h2A] = 8'h58;
        @(negedge clk);
        req1 = 1'b0;
        add_row(2); add_row(2);
        wait_bytes(34, 400);
        repeat (40) @(posedge clk);
        cmp_bus("stream", 0);

        // Reset in the middle of an enable pulse
        @(negedge clk);
        req0 = 1'b1; addr0 = 6'h00; data0 = 8'h20;
        @(negedge clk);
        req0 = 1'b0;
        begin
            int k = 0;
            while (!lcd_en && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        check("mid_en_seen", lcd_en, 1);
        rst = 1'b1;
        #1 check("mid_en_drop", lcd_en, 0);
        check("mid_done", init_done, 0);
        check("mid_data", lcd_data, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        clear_bus();
        init_seq(rel, "reinit");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/lcd12864_ctrl.md
# lcd12864_ctrl

Owns the LCD12864 (ST7920-class, 8-bit parallel, write-only) bus. It initialises the panel, then keeps the screen in sync with a 64-byte shadow text buffer (4 rows × 16 bytes). Two independent requesters write characters into that buffer through a round-robin arbiter. A row scheduler streams only the dirty rows to the panel, so application logic never has to sequence LCD commands.

## Interface

Parameters:
- DIV, 8000: clk cycles per lcd_en phase (low phase and high phase each last DIV cycles); must be ≥2.
- CLR_WAIT, 80000: idle clk cycles inserted after the 0x01 clear command.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 write request; held until granted.
- addr0  in  6  port 0 cell address: [5:4] row, [3:0] byte column.
- data0  in  8  port 0 byte (ASCII, or one half of a GB2312 code).
- gnt0  out  1  port 0 grant (combinational); write commits on the edge where req0&gnt0.
- req1, addr1, data1, gnt1: same as port 0, for port 1.
- init_done  out  1  high once the init sequence has completed.
- busy  out  1  high while any LCD byte slot or the clear wait is in progress.
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_rw  out  1  tied 0.
- lcd_en  out  1  enable strobe; the panel latches on its falling edge.
- lcd_data  out  8  bus data.

## Operation

- Shadow buffer: 64×8 bits. Reset fills every byte with 0x20 (space). Reads are only done by the scheduler.
- Arbiter:
  - If exactly one req is high, that port is granted.
  - If both are high, the port not granted last is granted.
  - The pointer resets so that port 0 wins the first conflict.
  - At most one grant per cycle.
  - Writes are accepted in every state, including during init and while a row is streaming.
  - A granted write sets dirty[addr[5:4]].
- Dirty bits: 4 bits, all set at reset so the first refresh paints the whole screen.
- FSM states: INIT, WAIT_CLR, IDLE, ROW_ADDR, ROW_DATA.
- INIT: sends commands 0x30, 0x30, 0x0C, 0x01 (lcd_rs=0).
- WAIT_CLR: waits CLR_WAIT cycles, then sends 0x06 and enters IDLE. init_done rises in the cycle IDLE is entered.
- IDLE: if any dirty bit is set, selects a row by round-robin, searching from the last-served row+1. The row pointer resets to 3, so row 0 is searched first. On selection the FSM clears that row's dirty bit and moves to ROW_ADDR.
- ROW_ADDR: sends the command 0x80/0x90/0x88/0x98 for row 0/1/2/3, then moves to ROW_DATA.
- ROW_DATA: sends 16 data bytes (lcd_rs=1), columns 0..15 in order. Each byte is read from the buffer at the start of its slot. After column 15 the FSM returns to IDLE.
- Write to the row currently streaming:
  - The dirty bit is set again and the row is re-sent on a later pass.
  - If the written column has not yet been sent, the new value goes out in the current pass.
- Write in the same cycle the scheduler clears the same row's dirty bit: the set wins, and the bit stays 1.

## Timing

- Byte slot is 2·DIV+1 clk cycles:
  - Slot cycle 0: lcd_rs and lcd_data are updated.
  - Cycles 0..DIV-1: lcd_en=0.
  - Cycles DIV..2·DIV-1: lcd_en=1.
  - Cycle 2·DIV: lcd_en=0, with data and rs still held.
  - The next slot may start on the following cycle.
- lcd_data and lcd_rs change only at slot cycle 0.
- Back-to-back slots within ROW_ADDR/ROW_DATA have no gap. IDLE→ROW_ADDR takes one cycle.
- Time to refresh one row is 17·(2·DIV+1) cycles.
- Reset values: lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, gnt0=gnt1=0, init_done=0, busy=0. The state is INIT, and the first slot starts on the first cycle after rst deasserts.
- rst asserted mid-slot: lcd_en drops immediately, and the whole sequence, including init, restarts.

## Test plan

All scenarios use DIV=2 and CLR_WAIT=10.
- Reset release: the bus must show 0x30, 0x30, 0x0C, 0x01, then 10 idle cycles, then 0x06. Each byte has 2 en-high cycles and a 5-cycle slot. init_done must rise afterwards.
- Post-init paint: rows 0,1,2,3 are sent in that order, each as its address command followed by 16×0x20 with rs=1. busy then falls, and no further bus activity occurs.
- Single write (idle): req0, addr0=0x13, data0=0x41 → gnt0 for one cycle. Row 1 is re-sent as 0x90, 0x20, 0x20, 0x20, 0x41, then 12×0x20.
- Conflict: req0 and req1 both held on consecutive cycles → grants go port 0, then port 1, then port 0. Exactly one gnt is high per cycle, and both writes appear on the bus.
- Write during streaming: during row 2 column 3, write addr=0x2A (column 10), data=0x58 → 0x58 appears in the current pass. Row 2 is then sent once more.
- Reset mid-slot: assert rst while lcd_en=1 → lcd_en=0 in the same cycle. After release the bus restarts from the first 0x30, and init_done=0 until init completes.
